// File: rtl/vga_link_monitor.sv
// vga_link_monitor: receive-side checker for a VGA hsync/vsync/rgb bundle.
// Recovers pixel coordinates, verifies line and frame timing, reports lock
// and timing errors, and accumulates a 16-bit per-frame pixel checksum.

module vga_link_monitor #(
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int H_ACTIVE = 640,
   parameter int H_TOTAL  = 800,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int V_ACTIVE = 480,
   parameter int V_TOTAL  = 525,
   parameter int SYNC_LOW = 1
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        pix_en,
   input  logic        hsync,
   input  logic        vsync,
   input  logic [11:0] rgb,
   output logic        locked,
   output logic        timing_err,
   output logic        frame_done,
   output logic [15:0] frame_sum,
   output logic        pix_valid,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic [11:0] pix_rgb
);

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   localparam logic [9:0]  H_ACT_LO  = 10'(H_SYNC + H_BP);
   localparam logic [9:0]  H_ACT_HI  = 10'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [9:0]  V_ACT_LO  = 10'(V_SYNC + V_BP);
   localparam logic [9:0]  V_ACT_HI  = 10'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [10:0] H_SYNC_W  = 11'(H_SYNC);
   localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
   localparam logic [10:0] V_TOTAL_W = 11'(V_TOTAL);

   state_t      state_q, state_d;
   logic [9:0]  h_pos_q, h_pos_d;
   logic [9:0]  v_line_q, v_line_d;
   logic        hs_prev_q, hs_prev_d;
   logic        vs_prev_q, vs_prev_d;
   logic        skip_q, skip_d;
   logic [15:0] acc_q, acc_d;
   logic        locked_q, locked_d;
   logic        timing_err_q, timing_err_d;
   logic        frame_done_q, frame_done_d;
   logic [15:0] frame_sum_q, frame_sum_d;
   logic        pix_valid_q, pix_valid_d;
   logic [9:0]  pix_x_q, pix_x_d;
   logic [9:0]  pix_y_q, pix_y_d;
   logic [11:0] pix_rgb_q, pix_rgb_d;

   logic hs_now, vs_now, hs_rise, hs_fall, vs_rise;
   logic pix_active, checking, any_err;

   // Syncs normalised to active-high; edges only count on pixel strobes.
   assign hs_now  = (SYNC_LOW != 0) ? ~hsync : hsync;
   assign vs_now  = (SYNC_LOW != 0) ? ~vsync : vsync;
   assign hs_rise = pix_en & hs_now & ~hs_prev_q;
   assign hs_fall = pix_en & ~hs_now & hs_prev_q;
   assign vs_rise = pix_en & vs_now & ~vs_prev_q;

   // The position of the sample being taken is the updated counter value.
   assign pix_active = pix_en
                     & (h_pos_d >= H_ACT_LO) & (h_pos_d < H_ACT_HI)
                     & (v_line_d >= V_ACT_LO) & (v_line_d < V_ACT_HI);

   assign checking = (state_q != ST_SEARCH);

   // Sync width at deassertion, line length and frame length at assertion.
   // The line check is skipped for the first line after entering MEASURE.
   assign any_err = checking & (
        (hs_fall & (({1'b0, h_pos_q} + 11'd1) != H_SYNC_W))
      | (hs_rise & ~skip_q & (({1'b0, h_pos_q} + 11'd1) != H_TOTAL_W))
      | (vs_rise & (({1'b0, v_line_q} + 11'd1) != V_TOTAL_W)));

   // Position counters, sync history, first-line skip flag and checksum.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and infers a latch.
      h_pos_d   = h_pos_q;
      v_line_d  = v_line_q;
      hs_prev_d = hs_prev_q;
      vs_prev_d = vs_prev_q;
      skip_d    = skip_q;
      if (pix_en) begin
         hs_prev_d = hs_now;
         vs_prev_d = vs_now;
         if (hs_rise)                 h_pos_d = '0;
         else if (h_pos_q != 10'h3FF) h_pos_d = h_pos_q + 10'd1;
         if (vs_rise)                            v_line_d = '0;
         else if (hs_rise && v_line_q != 10'h3FF) v_line_d = v_line_q + 10'd1;
         if (!checking && vs_rise) skip_d = 1'b1;
         else if (hs_rise)         skip_d = 1'b0;
      end
      acc_d = acc_q;
      if (vs_rise)         acc_d = '0;
      else if (pix_active) acc_d = acc_q + {4'd0, rgb};
   end

   // Next-state logic: an error always drops back to SEARCH.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_SEARCH:  if (vs_rise) state_d = ST_MEASURE;
         ST_MEASURE: if (any_err) state_d = ST_SEARCH;
                     else if (vs_rise) state_d = ST_LOCKED;
         ST_LOCKED:  if (any_err) state_d = ST_SEARCH;
         default:    state_d = ST_SEARCH;
      endcase
   end

   // Output logic: pulses, lock flag, checksum latch and pixel report.
   always_comb begin
      timing_err_d = any_err;
      frame_done_d = checking & vs_rise & ~any_err;
      locked_d     = (state_d == ST_LOCKED);
      frame_sum_d  = frame_done_d ? acc_q : frame_sum_q;
      pix_valid_d  = checking & pix_active;
      pix_x_d      = pix_x_q;
      pix_y_d      = pix_y_q;
      pix_rgb_d    = pix_rgb_q;
      if (pix_valid_d) begin
         pix_x_d   = h_pos_d - H_ACT_LO;
         pix_y_d   = v_line_d - V_ACT_LO;
         pix_rgb_d = rgb;
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge sys_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!sys_rst_n) state_q <= ST_SEARCH;
      else            state_q <= state_d;
   end

   // Datapath and output registers.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         h_pos_q      <= '0;
         v_line_q     <= '0;
         hs_prev_q    <= 1'b0;
         vs_prev_q    <= 1'b0;
         skip_q       <= 1'b0;
         acc_q        <= '0;
         locked_q     <= 1'b0;
         timing_err_q <= 1'b0;
         frame_done_q <= 1'b0;
         frame_sum_q  <= '0;
         pix_valid_q  <= 1'b0;
         pix_x_q      <= '0;
         pix_y_q      <= '0;
         pix_rgb_q    <= '0;
      end else begin
         h_pos_q      <= h_pos_d;
         v_line_q     <= v_line_d;
         hs_prev_q    <= hs_prev_d;
         vs_prev_q    <= vs_prev_d;
         skip_q       <= skip_d;
         acc_q        <= acc_d;
         locked_q     <= locked_d;
         timing_err_q <= timing_err_d;
         frame_done_q <= frame_done_d;
         frame_sum_q  <= frame_sum_d;
         pix_valid_q  <= pix_valid_d;
         pix_x_q      <= pix_x_d;
         pix_y_q      <= pix_y_d;
         pix_rgb_q    <= pix_rgb_d;
      end
   end

   assign locked     = locked_q;
   assign timing_err = timing_err_q;
   assign frame_done = frame_done_q;
   assign frame_sum  = frame_sum_q;
   assign pix_valid  = pix_valid_q;
   assign pix_x      = pix_x_q;
   assign pix_y      = pix_y_q;
   assign pix_rgb    = pix_rgb_q;

endmodule

// File: tb/tb_vga_link_monitor.sv
// tb_vga_link_monitor: drives scripted VGA frames (reduced geometry) into
// vga_link_monitor, predicts pixel reports and frame checksums into queues,
// and compares them as the DUT produces them.

module tb_vga_link_monitor;

   localparam int H_SYNC   = 4;
   localparam int H_BP     = 3;
   localparam int H_ACTIVE = 16;
   localparam int H_TOTAL  = 26;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 2;
   localparam int V_ACTIVE = 8;
   localparam int V_TOTAL  = 14;
   localparam int HA0      = H_SYNC + H_BP;
   localparam int VA0      = V_SYNC + V_BP;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n;
   logic        pix_en;
   logic        hsync;
   logic        vsync;
   logic [11:0] rgb;
   logic        locked;
   logic        timing_err;
   logic        frame_done;
   logic [15:0] frame_sum;
   logic        pix_valid;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic [11:0] pix_rgb;

   vga_link_monitor #(
      .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL),
      .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL),
      .SYNC_LOW(1)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pix_en(pix_en),
      .hsync(hsync), .vsync(vsync), .rgb(rgb),
      .locked(locked), .timing_err(timing_err), .frame_done(frame_done),
      .frame_sum(frame_sum), .pix_valid(pix_valid), .pix_x(pix_x),
      .pix_y(pix_y), .pix_rgb(pix_rgb)
   );

   always #5 sys_clk = ~sys_clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard queues and reference-model state.
   logic [31:0] pix_q[$];
   logic [15:0] sum_q[$];
   int          err_seen = 0;
   int          fd_seen  = 0;
   int          pix_cnt  = 0;
   int          m_state  = 0;   // 0 search, 1 measure, 2 locked
   bit          m_skip   = 1'b0;
   int          m_prev_len   = H_TOTAL;
   int          m_prev_lines = V_TOTAL;
   int          exp_err  = 0;
   int          exp_fd   = 0;
   logic [15:0] m_sum    = '0;
   bit          in_rst   = 1'b0;

   // Monitor: sample away from the rising edge and pop expectations.
   always @(negedge sys_clk) begin
      if (pix_valid) begin
         pix_cnt++;
         if (pix_q.size() == 0) check("pix_extra", 32'(pix_valid), 32'd0);
         else check("pix", {pix_x, pix_y, pix_rgb}, pix_q.pop_front());
      end
      if (frame_done) begin
         fd_seen++;
         if (sum_q.size() == 0) check("fd_extra", 32'(frame_done), 32'd0);
         else check("frame_sum", 32'(frame_sum), 32'(sum_q.pop_front()));
      end
      if (timing_err) err_seen++;
   end

   // Reference model step for one pixel sample, using pre-sample state.
   task automatic model_step(input int h, input int ln, input int sw, input logic [11:0] c);
      bit hr, vr, hf, act, err;
      int old;
      hr  = (h == 0);
      vr  = hr && (ln == 0);
      hf  = (h == sw);
      act = (h >= HA0) && (h < HA0 + H_ACTIVE) && (ln >= VA0) && (ln < VA0 + V_ACTIVE);
      old = m_state;
      err = 1'b0;
      if (old != 0) begin
         if (hf && sw != H_SYNC)                    err = 1'b1;
         if (hr && !m_skip && m_prev_len != H_TOTAL) err = 1'b1;
         if (vr && m_prev_lines != V_TOTAL)          err = 1'b1;
      end
      if (old != 0 && act) pix_q.push_back({10'(h - HA0), 10'(ln - VA0), c});
      if (err) begin
         exp_err++;
         m_state = 0;
      end else if (vr) begin
         if (old == 0) m_state = 1;
         else begin
            sum_q.push_back(m_sum);
            exp_fd++;
            m_state = 2;
         end
      end
      if (old == 0 && vr) m_skip = 1'b1;
      else if (hr)        m_skip = 1'b0;
      if (vr)  m_sum = '0;
      if (act) m_sum = m_sum + {4'd0, c};
   endtask

   // One pixel: strobe cycle, then an idle cycle with junk on the inputs.
   task automatic drive_pix(input logic hs, input logic vs, input logic [11:0] c);
      @(negedge sys_clk);
      hsync  = ~hs;
      vsync  = ~vs;
      rgb    = c;
      pix_en = 1'b1;
      @(negedge sys_clk);
      pix_en = 1'b0;
      hsync  = 1'($urandom);
      vsync  = 1'($urandom);
      rgb    = 12'($urandom);
   endtask

   task automatic pulse_reset();
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      check("rst_flags", {locked, timing_err, frame_done, pix_valid, pix_x, pix_y}, 32'd0);
      check("rst_sum", 32'(frame_sum), 32'd0);
      check("rst_rgb", 32'(pix_rgb), 32'd0);
      m_state = 0;
      m_sum   = '0;
   endtask

   task automatic gen_frame(input int n_lines, input int short_line, input int short_sync,
                            input int rst_line, input logic [11:0] base, input bit ramp);
      int len, sw;
      logic [11:0] c;
      for (int ln = 0; ln < n_lines; ln++) begin
         len = (ln == short_line) ? H_TOTAL - 1 : H_TOTAL;
         sw  = (ln == short_sync) ? H_SYNC - 1 : H_SYNC;
         for (int h = 0; h < len; h++) begin
            c = ramp ? 12'(int'(base) + h * 37 + ln * 101) : base;
            if (!in_rst) model_step(h, ln, sw, c);
            drive_pix(h < sw, ln < V_SYNC, c);
            if (ln == rst_line && h == 10) pulse_reset();
         end
         m_prev_len = len;
      end
      m_prev_lines = n_lines;
      check("pix_drained", 32'(pix_q.size()), 32'd0);
   endtask

   int fd_mark, err_mark;

   initial begin
      sys_rst_n = 1'b0;
      pix_en    = 1'b0;
      hsync     = 1'b1;
      vsync     = 1'b1;
      rgb       = '0;
      repeat (3) @(negedge sys_clk);
      check("reset_flags", {locked, timing_err, frame_done, pix_valid, pix_x, pix_y}, 32'd0);
      check("reset_sum", 32'(frame_sum), 32'd0);
      check("reset_rgb", 32'(pix_rgb), 32'd0);

      // A whole frame under reset produces nothing.
      in_rst = 1'b1;
      gen_frame(V_TOTAL, -1, -1, -1, 12'h001, 1'b0);
      check("rst_hold_err", 32'(err_seen), 32'd0);
      check("rst_hold_fd", 32'(fd_seen), 32'd0);
      check("rst_hold_locked", 32'(locked), 32'd0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      in_rst    = 1'b0;

      // Ideal timing, constant colour 001: lock at the second vsync.
      pix_cnt = 0;
      gen_frame(V_TOTAL, -1, -1, -1, 12'h001, 1'b0);
      check("measure_locked", 32'(locked), 32'd0);
      check("pix_per_frame", 32'(pix_cnt), 32'(H_ACTIVE * V_ACTIVE));
      gen_frame(V_TOTAL, -1, -1, -1, 12'h001, 1'b0);
      check("locked_2nd_vs", 32'(locked), 32'd1);
      check("sum_001", 32'(frame_sum), 32'h0080);

      // Colour FFF wraps the accumulator.
      gen_frame(V_TOTAL, -1, -1, -1, 12'hFFF, 1'b0);
      gen_frame(V_TOTAL, -1, -1, -1, 12'hFFF, 1'b0);
      check("sum_fff", 32'(frame_sum), 32'hFF80);

      // Short line while locked.
      err_mark = err_seen;
      gen_frame(V_TOTAL, 5, -1, -1, 12'h123, 1'b1);
      check("short_line_err", 32'(err_seen - err_mark), 32'd1);
      check("short_line_unlock", 32'(locked), 32'd0);
      check("short_line_sum_hold", 32'(frame_sum), 32'hFF80);
      gen_frame(V_TOTAL, -1, -1, -1, 12'h2A5, 1'b1);
      check("relock_a_pending", 32'(locked), 32'd0);
      gen_frame(V_TOTAL, -1, -1, -1, 12'h7C3, 1'b1);
      check("relock_a", 32'(locked), 32'd1);

      // Short hsync pulse while locked.
      err_mark = err_seen;
      gen_frame(V_TOTAL, -1, 3, -1, 12'h456, 1'b1);
      check("short_sync_err", 32'(err_seen - err_mark), 32'd1);
      check("short_sync_unlock", 32'(locked), 32'd0);
      gen_frame(V_TOTAL, -1, -1, -1, 12'h00F, 1'b0);
      gen_frame(V_TOTAL, -1, -1, -1, 12'h0F0, 1'b0);
      check("relock_b", 32'(locked), 32'd1);

      // Short frame: the error at the next vsync suppresses frame_done.
      gen_frame(V_TOTAL - 1, -1, -1, -1, 12'h321, 1'b1);
      fd_mark  = fd_seen;
      err_mark = err_seen;
      gen_frame(V_TOTAL, -1, -1, -1, 12'h001, 1'b0);
      check("short_frame_err", 32'(err_seen - err_mark), 32'd1);
      check("short_frame_no_fd", 32'(fd_seen - fd_mark), 32'd0);
      check("short_frame_unlock", 32'(locked), 32'd0);
      gen_frame(V_TOTAL, -1, -1, -1, 12'h001, 1'b0);
      gen_frame(V_TOTAL, -1, -1, -1, 12'h001, 1'b0);
      check("relock_c", 32'(locked), 32'd1);

      // One-cycle reset mid-frame while locked.
      gen_frame(V_TOTAL, -1, -1, 6, 12'hABC, 1'b1);
      gen_frame(V_TOTAL, -1, -1, -1, 12'h001, 1'b0);
      check("relock_d_pending", 32'(locked), 32'd0);
      gen_frame(V_TOTAL, -1, -1, -1, 12'h001, 1'b0);
      check("relock_d", 32'(locked), 32'd1);

      repeat (4) @(negedge sys_clk);
      check("err_total", 32'(err_seen), 32'(exp_err));
      check("fd_total", 32'(fd_seen), 32'(exp_fd));
      check("sum_q_drained", 32'(sum_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_link_monitor.md
# vga_link_monitor

Receive-side counterpart of the VGA output path: samples the `hsync`/`vsync`/`rgb` bundle that `top` drives off-chip and recovers pixel coordinates from it. It checks line and frame timing against the configured 640x480@60 parameters, reports lock and timing errors, and produces a per-frame 16-bit pixel checksum. It is used as an on-chip loopback checker and as the scoreboard front-end in VGA benches.

## Interface
Parameters:
- `H_SYNC`, 96: hsync pulse width, in pixels.
- `H_BP`, 48: horizontal back porch.
- `H_ACTIVE`, 640: active pixels per line.
- `H_TOTAL`, 800: pixels per line.
- `V_SYNC`, 2: vsync width, in lines.
- `V_BP`, 33: vertical back porch.
- `V_ACTIVE`, 480: active lines per frame.
- `V_TOTAL`, 525: lines per frame.
- `SYNC_LOW`, 1: 1 means syncs are active-low.

Ports:
- `sys_clk`  in  1  system clock. One clock; all logic is on its rising edge.
- `sys_rst_n`  in  1  reset, synchronous and active-low.
- `pix_en`  in  1  pixel strobe, one `sys_clk` per pixel (÷4 of `sys_clk` in `top`).
- `hsync`  in  1  horizontal sync from the generator.
- `vsync`  in  1  vertical sync from the generator.
- `rgb`  in  12  pixel colour {R4,G4,B4}.
- `locked`  out  1  timing verified over at least one full frame.
- `timing_err`  out  1  one-cycle pulse on any timing mismatch.
- `frame_done`  out  1  one-cycle pulse when `frame_sum` updates.
- `frame_sum`  out  16  checksum of the last good frame.
- `pix_valid`  out  1  one-cycle pulse per active pixel.
- `pix_x`  out  10  active pixel column.
- `pix_y`  out  10  active pixel row.
- `pix_rgb`  out  12  active pixel colour.

## Operation
- Sampling:
  - Inputs are acted on only in cycles where `pix_en`=1.
  - Syncs are normalised to active-high (inverted when `SYNC_LOW`=1). They are compared with the previous sample to detect assertion edges `hs_rise` and `vs_rise`, and the deassertion edge `hs_fall`.
- Horizontal counter `h_pos` (10 bit):
  - Set to 0 on `hs_rise`; otherwise increments, saturating at 1023.
  - On `hs_fall`, the sync width is `h_pos`+1 and must equal `H_SYNC`.
  - On `hs_rise`, the line length is the old `h_pos`+1 and must equal `H_TOTAL`. This check is skipped for the first line after entering MEASURE.
- Line counter `v_line` (10 bit):
  - `vs_rise` sets it to 0. A coincident `hs_rise` does not increment it.
  - Otherwise `hs_rise` increments it, saturating at 1023.
  - On `vs_rise`, the old `v_line`+1 must equal `V_TOTAL`.
- Active region:
  - `h_pos` in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and `v_line` in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
  - Coordinates are `pix_x`=`h_pos`−(H_SYNC+H_BP) and `pix_y`=`v_line`−(V_SYNC+V_BP).
  - Coordinates are reported in every state except SEARCH.
- Checksum:
  - 16-bit accumulator adds zero-extended `rgb` for each active pixel, modulo 2^16. Cleared at every `vs_rise`.
- State machine (2-bit):
  - SEARCH: counters free-run, no checks, no `pix_valid`. On `vs_rise`, go to MEASURE and clear the accumulator.
  - MEASURE: all checks enabled. Any mismatch pulses `timing_err` and returns to SEARCH. On `vs_rise` with a correct frame length, go to LOCKED: latch `frame_sum`, pulse `frame_done`, set `locked`=1.
  - LOCKED: same checks. Each correct `vs_rise` latches `frame_sum` and pulses `frame_done`. Any mismatch pulses `timing_err`, clears `locked` and returns to SEARCH; `frame_sum` holds its last value.
- Simultaneous events:
  - On a failed frame-length check at `vs_rise`, the error wins: no `frame_done`, no latch.
  - A line-length error and a sync-width error in the same sample give a single `timing_err` pulse.

## Timing
- Reset values: state SEARCH; all outputs 0; `h_pos`, `v_line` and the accumulator are 0; the previous-sync registers take the inactive level.
- Reset mid-frame: everything returns to the above at the next edge. Relock needs two `vs_rise` edges after reset.
- Outputs are registered and appear in the `sys_clk` cycle after the `pix_en` cycle that sampled the corresponding inputs.
- `pix_valid`, `timing_err` and `frame_done` are exactly one `sys_clk` wide. `pix_x`, `pix_y` and `pix_rgb` hold until the next `pix_valid`.
- `frame_sum` and `frame_done` update together in the cycle after the `vs_rise` sample.
- Latency from the first correct `vs_rise` after SEARCH to `locked`: one full frame, 800×525 pixels.

## Test plan
- Reset with the syncs idle → all outputs 0. Hold reset across a frame → no `frame_done` and no `timing_err`.
- Ideal 800×525 timing, vsync asserted at the hsync start, `rgb`=12'h001:
  - `locked` rises at the second `vs_rise`.
  - `frame_sum`=16'hB000.
  - First `pix_valid` has (0,0); last `pix_valid` has (639,479); 307200 pulses per frame.
- Ideal timing with `rgb`=12'hFFF → `frame_sum`=16'h5000 on every `frame_done`.
- While locked, one line of 799 pixels → one `timing_err` pulse, `locked`=0, `frame_sum` unchanged. Relock two frames later.
- While locked, one hsync pulse of 95 pixels → `timing_err`, `locked` drops. A frame of 524 lines gives the same result with no `frame_done`.
- Assert `sys_rst_n`=0 for one cycle mid-frame while locked → `locked`=0 next cycle, outputs 0. `locked` returns after two `vs_rise` edges.
